// File: rtl/uart_string_tx.sv
// -----------------------------------------------------------------------------
// uart_string_tx
//
// Serialises a fixed-width ASCII string onto a UART TX line (8N1, idle high),
// one byte at a time in string order (byte 0 = most significant byte of
// display_string). The string is snapshotted when a start is accepted, so
// later changes on display_string cannot tear a transmission.
//
// Optional feature macro: UART_STRING_SKIP_NUL_EN
//   defined   -> bytes equal to 8'h00 are skipped (one LOAD cycle, no frame)
//   undefined -> every byte is framed, including 8'h00
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit
//   STR_BITS     : width of display_string, multiple of 8
//
// Ports
//   clk            : system clock, all logic on posedge
//   rst            : synchronous active-high reset
//   display_string : ASCII string, byte i = bits [STR_BITS-1-8i -: 8]
//   start          : transmission request, sampled only in IDLE
//   busy           : high from the cycle after an accepted start to completion
//   done           : one-cycle pulse when the last byte has finished
//   tx             : UART line
// -----------------------------------------------------------------------------
module uart_string_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STR_BITS     = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STR_BITS-1:0] display_string,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                tx
);

  localparam int NBYTES = STR_BITS / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBYTES - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                  r_state;
  // Element 0 is the most significant byte, so a direct assignment from
  // display_string puts string byte i at index i.
  logic [0:NBYTES-1][7:0]  r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic [BAUD_W-1:0]       r_baud;
  logic [2:0]              r_bit;
  logic [7:0]              r_byte;     // shifts right as bits go out
  logic                    r_busy;
  logic                    r_done;
  logic                    r_tx;

  logic [7:0]              w_cur_byte;
  logic                    w_skip;
  logic                    w_baud_end;
  logic                    w_last;
  logic                    w_accept;

  assign w_cur_byte = r_shadow[r_idx];
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_last     = (r_idx == IDX_LAST);

  // The cycle in which done pulses still belongs to the finished transfer,
  // so a start seen there is dropped even though the state is already IDLE.
  assign w_accept   = (r_state == S_IDLE) && start && !r_done;

`ifdef UART_STRING_SKIP_NUL_EN
  assign w_skip = (w_cur_byte == 8'h00);
`else
  assign w_skip = 1'b0;
`endif

  // Snapshot register: pure data path, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_shadow <= display_string;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_skip) begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_byte  <= w_cur_byte;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_tx   <= r_byte[1];
              r_byte <= {1'b0, r_byte[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_LOAD;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign tx   = r_tx;

endmodule

// File: tb/tb_uart_string_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_string_tx
//
// Self-checking bench for uart_string_tx (CLKS_PER_BIT=4, STR_BITS=5000).
// Expected bytes are pushed to a queue when a start is accepted; a UART
// receiver model pops and compares them as frames arrive on tx.
// Follows UART_STRING_SKIP_NUL_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_uart_string_tx;

  localparam int CPB = 4;
  localparam int SB  = 5000;
  localparam int NB  = SB / 8;

`ifdef UART_STRING_SKIP_NUL_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  localparam int EXP_SPARSE_FIRST = (SKIP != 0) ? NB : 1;
  localparam int EXP_SPARSE_DONE  = (SKIP != 0) ? (NB + 10 * CPB) : (NB * (1 + 10 * CPB));
  localparam int EXP_BOARD_FRAMES = (SKIP != 0) ? 527 : NB;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [SB-1:0] ds    = '0;
  logic          busy;
  logic          done;
  logic          tx;

  uart_string_tx #(
    .CLKS_PER_BIT(CPB),
    .STR_BITS    (SB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .display_string(ds),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int  done_cnt  = 0;
  int  done_cyc  = 0;
  int  first_low = -1;
  int  frames    = 0;
  bit  m_active  = 1'b0;
  int  m_cnt     = 0;
  logic [7:0] m_byte = '0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_byte(input int pos, input logic [7:0] v);
    ds[SB-1-8*pos -: 8] = v;
  endtask

  // Expected byte stream for the string currently on ds.
  task automatic push_expected();
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      b = ds[SB-1-8*i -: 8];
      if (SKIP == 0 || b != 8'h00) exp_q.push_back(b);
    end
  endtask

  // 17 lines of 29 chars + "\n\r" = 527 chars, right-aligned behind NULs.
  task automatic build_board();
    logic [7:0] c;
    ds = '0;
    for (int line = 0; line < 17; line++) begin
      for (int col = 0; col < 31; col++) begin
        if (col == 29)              c = 8'h0A;
        else if (col == 30)         c = 8'h0D;
        else if (line % 2 == 0)     c = 8'h2D;
        else if (col % 4 == 0)      c = 8'h7C;
        else if (col % 4 == 2)      c = 8'h30 + 8'((line * 7 + col) % 10);
        else                        c = 8'h20;
        set_byte(NB - 527 + line * 31 + col, c);
      end
    end
  endtask

  // UART receiver + done monitor, sampled on the falling edge.
  initial begin : monitor
    int k;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (tx === 1'b0) begin
          m_active = 1'b1;
          m_cnt    = 0;
          m_byte   = '0;
          if (first_low < 0) first_low = cyc;
        end
      end else begin
        m_cnt++;
        if (m_cnt % CPB == CPB / 2) begin
          k = m_cnt / CPB;
          if (k == 0) begin
            check("start_bit", int'(tx), 0);
          end else if (k <= 8) begin
            m_byte[k-1] = tx;
          end else begin
            check("stop_bit", int'(tx), 1);
            frames++;
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else                   check("byte", int'(m_byte), int'(exp_q.pop_front()));
            m_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : main
    int t;
    int t0;
    int dc0;
    int fr0;
    logic [SB-1:0] board_ds;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx", int'(tx), 1);
    $display("reset released at cycle %0d", cyc);

    // Board string, with start pulses and string toggling during transfer
    build_board();
    board_ds = ds;
    push_expected();
    dc0   = done_cnt;
    fr0   = frames;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("board_busy", int'(busy), 1);
    for (t = 0; t < 40000; t++) begin
      @(negedge clk);
      if (done) break;
      start = (t % 97 == 5);
      if (t % 500 == 250) ds = ~ds;
    end
    check("board_done_seen", int'(done), 1);
    check("board_frames", frames - fr0, EXP_BOARD_FRAMES);
    check("board_queue_empty", exp_q.size(), 0);
    $display("board transfer: %0d frames, done at cycle %0d", frames - fr0, cyc);

    // Start during the done cycle is ignored; one cycle later is accepted
    ds    = board_ds;
    start = 1'b1;
    @(negedge clk);
    check("start_on_done_ignored", int'(busy), 0);
    push_expected();
    @(negedge clk);
    start = 1'b0;
    check("start_after_done_busy", int'(busy), 1);
    check("board_one_done", done_cnt - dc0, 1);
    $display("restart after done accepted at cycle %0d", cyc);

    // Reset in the middle of DATA
    for (t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (m_active && m_cnt >= 10) break;
    end
    check("reached_data", int'(m_active), 1);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    $display("mid-frame reset at cycle %0d", cyc);

    // Sparse string: only the last byte is non-zero
    ds = '0;
    set_byte(NB - 1, 8'h41);
    push_expected();
    first_low = -1;
    dc0   = done_cnt;
    fr0   = frames;
    start = 1'b1;
    @(negedge clk);
    t0    = cyc;
    start = 1'b0;
    check("sparse_busy", int'(busy), 1);
    for (t = 0; t < 30000; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check("sparse_done_seen", int'(done), 1);
    @(negedge clk);
    check("sparse_first_low", first_low - t0, EXP_SPARSE_FIRST);
    check("sparse_done_time", done_cyc - t0, EXP_SPARSE_DONE);
    check("sparse_one_done", done_cnt - dc0, 1);
    check("sparse_frames", frames - fr0, (SKIP != 0) ? 1 : NB);
    check("sparse_busy_low", int'(busy), 0);
    check("sparse_done_pulse", int'(done), 0);
    check("sparse_queue_empty", exp_q.size(), 0);
    $display("sparse transfer: %0d frames, done %0d cycles after start", frames - fr0, done_cyc - t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
